// File: rtl/bss_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package bss_pkg;
  localparam int BSS_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } bss_state_e;
endpackage

// File: rtl/bss_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module bss_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial subtractor computing A-B over WIDTH clocks.
// Optional macro BIT_SERIAL_SUB_SAT_EN: a borrowing result is presented as 0.
//
// state  | meaning
// IDLE   | no operands captured
// LOADED | operands captured, waiting for start
// SHIFT  | one bit processed per clock
// DONE   | diff/borrow/done held until next load
module bit_serial_subtractor
  import bss_pkg::*;
#(
  parameter int WIDTH = BSS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  bss_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             br_q, borrow_q, done_q;

  logic             fs_d, fs_bout;
  logic [WIDTH-1:0] res_d, final_diff;

  bss_full_subtractor u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (br_q),
    .d_o   (fs_d),
    .bout_o(fs_bout)
  );

  assign res_d = {fs_d, res_q[WIDTH-1:1]};

`ifdef BIT_SERIAL_SUB_SAT_EN
  assign final_diff = fs_bout ? '0 : res_d;
`else
  assign final_diff = res_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            a_q      <= A;
            b_q      <= B;
            br_q     <= 1'b0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= LOADED;
          end
        end
        LOADED: begin
          if (load) begin
            a_q <= A;
            b_q <= B;
          end else if (start) begin
            cnt_q   <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= fs_bout;
          res_q <= res_d;
          if (cnt_q == CNT_LAST) begin
            diff_q   <= final_diff;
            borrow_q <= fs_bout;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign done   = done_q;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench: arithmetic reference model plus directed and random operations.
module tb_bit_serial_subtractor;
  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         done;

  int errors = 0;
  int checks = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .start (start),
    .A     (A),
    .B     (B),
    .diff  (diff),
    .borrow(borrow),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 empty, 1 holding operands, 2 busy, 3 result ready
  int m_phase = 0;
  int m_rem = 0;
  int m_a = 0;
  int m_b = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_rem = 0;
      m_a = 0;
      m_b = 0;
    end else begin
      case (m_phase)
        0, 3: if (load) begin m_a = int'(A); m_b = int'(B); m_phase = 1; end
        1: begin
          if (load) begin m_a = int'(A); m_b = int'(B); end
          else if (start) begin m_phase = 2; m_rem = W; end
        end
        default: begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_phase = 3;
        end
      endcase
    end
  end

  function automatic int exp_diff(input int a, input int b);
`ifdef BIT_SERIAL_SUB_SAT_EN
    if (a < b) return 0;
`endif
    return (a - b) & MASK;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_done", int'(done), (m_phase == 3) ? 1 : 0);
      check("cyc_diff", int'(diff), (m_phase == 3) ? exp_diff(m_a, m_b) : 0);
      check("cyc_borrow", int'(borrow), (m_phase == 3 && m_a < m_b) ? 1 : 0);
    end
  end

  task automatic do_load(input int a, input int b);
    @(negedge clk);
    load = 1'b1; A = W'(a); B = W'(b);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start_wait(input string name);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
    end
    check({name, "_latency"}, n, W);
  endtask

  task automatic run_op(input string name, input int a, input int b, input int ed, input int eb);
    do_load(a, b);
    pulse_start_wait(name);
    check({name, "_diff"}, int'(diff), ed);
    check({name, "_borrow"}, int'(borrow), eb);
  endtask

  initial begin
    int a, b, sat_d;
    #23;
    check("reset_done", int'(done), 0);
    check("reset_diff", int'(diff), 0);
    check("reset_borrow", int'(borrow), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // start in IDLE is ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("idle_start_done", int'(done), 0);

    run_op("a9b4", 9, 4, 5, 0);
`ifdef BIT_SERIAL_SUB_SAT_EN
    sat_d = 0;
`else
    sat_d = 14;
`endif
    run_op("a3b5", 3, 5, sat_d, 1);
    repeat (3) @(negedge clk);
    check("done_hold", int'(done), 1);
    check("done_hold_diff", int'(diff), sat_d);
    run_op("a15b15", 15, 15, 0, 0);
    run_op("a0b0", 0, 0, 0, 0);
`ifdef BIT_SERIAL_SUB_SAT_EN
    run_op("a0b1", 0, 1, 0, 1);
`else
    run_op("a0b1", 0, 1, 15, 1);
`endif

    // reload in LOADED, load beats start
    do_load(8, 2);
    check("load_clears_done", int'(done), 0);
    do_load(7, 7);
    @(negedge clk); load = 1'b1; start = 1'b1; A = 4'd7; B = 4'd7;
    @(negedge clk); load = 1'b0; start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("load_beats_start", int'(done), 0);
    pulse_start_wait("a7b7");
    check("a7b7_diff", int'(diff), 0);
    check("a7b7_borrow", int'(borrow), 0);

    // load and start during SHIFT are ignored
    do_load(6, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; load = 1'b1; A = 4'd12; B = 4'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b0;
    repeat (W) @(negedge clk);
    check("shift_ignore_done", int'(done), 1);
    check("shift_ignore_diff", int'(diff), 5);

    // reset mid-SHIFT
    do_load(6, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_borrow", int'(borrow), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("post_rst_idle", int'(done), 0);
    run_op("post_rst_a13b6", 13, 6, 7, 0);

    // random operations, with start noise while results are held
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(MASK, 0));
      b = int'($urandom_range(MASK, 0));
      run_op("rand", a, b, exp_diff(a, b), (a < b) ? 1 : 0);
      repeat ($urandom_range(3, 0)) begin
        @(negedge clk);
        start = 1'($urandom_range(1, 0));
      end
      @(negedge clk); start = 1'b0;
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port load  input  1  capture A and B into operand shift registers.
REQ-005 SHALL have port start  input  1  begin serial subtraction of loaded operands.
REQ-006 SHALL have port A  input  WIDTH  minuend.
REQ-007 SHALL have port B  input  WIDTH  subtrahend.
REQ-008 SHALL have port diff  output  WIDTH  result A-B, valid while done=1.
REQ-009 SHALL have port borrow  output  1  final borrow-out (A<B unsigned), valid while done=1.
REQ-010 SHALL have port done  output  1  level flag, result valid.

Function
REQ-011 SHALL implement FSM states IDLE, LOADED, SHIFT, DONE.
REQ-012 SHALL, in IDLE or DONE with load=1, capture A, B, clear internal borrow, clear diff, clear done, go to LOADED.
REQ-013 SHALL, in LOADED with load=1, recapture A and B and stay in LOADED (load beats start).
REQ-014 SHALL, in LOADED with load=0 and start=1, clear bit counter and go to SHIFT.
REQ-015 SHALL, per SHIFT cycle, process LSB-first: d = a0^b0^br; br_next = (~a0&b0)|(~(a0^b0)&br); shift d into result MSB; shift operands right.
REQ-016 SHALL, at the edge completing the WIDTH-th SHIFT bit, go to DONE with done=1, diff=A-B mod 2^WIDTH, borrow=final br.
REQ-017 SHALL give latency: start sampled at edge N -> done visible after edge N+WIDTH.
REQ-018 SHALL ignore load and start during SHIFT; operands and result unaffected.
REQ-019 SHALL ignore start in IDLE and DONE.
REQ-020 SHALL hold diff, borrow, done in DONE until next load or reset.
REQ-021 SHALL keep diff and borrow at 0 and done=0 in IDLE, LOADED, SHIFT.

Reset
REQ-022 SHALL, on rst_n=0 at any time including mid-SHIFT, asynchronously force state IDLE, counter 0, operand regs 0, internal borrow 0, diff=0, borrow=0, done=0.
REQ-023 SHALL resume normal operation at the first rising clk edge after rst_n deasserts; no partial result survives.

Configuration
REQ-024 SHALL support macro BIT_SERIAL_SUB_SAT_EN: when defined, a DONE result with borrow=1 presents diff=0 (saturate at zero), borrow still 1.
REQ-025 SHALL, without BIT_SERIAL_SUB_SAT_EN, present the wrapped two's-complement diff.

Structure
REQ-026 SHALL place the state enum typedef and default WIDTH localparam in shared package bss_pkg.
REQ-027 SHALL implement the one-bit cell (a, b, bin -> d, bout) as combinational sub-module bss_full_subtractor, instantiated once.

Verification
REQ-028 SHALL cover: WIDTH=4, load A=9 B=4, start -> after 4 cycles done=1, diff=5, borrow=0.
REQ-029 SHALL cover: A=3 B=5 -> diff=14 borrow=1 (macro off); diff=0 borrow=1 (BIT_SERIAL_SUB_SAT_EN on).
REQ-030 SHALL cover: A=15 B=15 and A=0 B=0 -> diff=0 borrow=0; A=0 B=1 -> diff=15 borrow=1 (macro off).
REQ-031 SHALL cover: load A=8 B=2 then load A=7 B=7 in LOADED and load+start same cycle -> stays LOADED; start -> diff=0.
REQ-032 SHALL cover: load A=12 B=3 during SHIFT of A=6 B=1 -> ignored, diff=5; rst_n low after 2 SHIFT cycles -> all outputs 0, state IDLE, next load/start gives correct result.
